// File: rtl/pulse_burst_gen.sv
// Programmable burst generator: emits N rectangular pulses with configurable
// high/low phase lengths and reports busy, done and the number of pulses sent.
module pulse_burst_gen #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned PHASE_W = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               abort,
  input  logic [CNT_W-1:0]   burst_count,
  input  logic [PHASE_W-1:0] high_cycles,
  input  logic [PHASE_W-1:0] low_cycles,
  output logic               pulse_out,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   pulses_sent
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [PHASE_W-1:0] PHASE_ONE = PHASE_W'(1);
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   burst_q, burst_d;
  logic [PHASE_W-1:0] high_q, high_d;
  logic [PHASE_W-1:0] low_q, low_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [CNT_W-1:0]   sent_d;
  logic               pulse_d, busy_d, done_d;
  logic [PHASE_W-1:0] high_clamp_c, low_clamp_c;

  // Zero phase lengths become one cycle so a pulse is never stuck or zero-width.
  assign high_clamp_c = (high_cycles == '0) ? PHASE_ONE : high_cycles;
  assign low_clamp_c  = (low_cycles  == '0) ? PHASE_ONE : low_cycles;

  // Next-state and next-output logic; done is a strobe so it defaults low.
  always_comb begin
    state_d = state_q;
    burst_d = burst_q;
    high_d  = high_q;
    low_d   = low_q;
    phase_d = phase_q;
    sent_d  = pulses_sent;
    pulse_d = pulse_out;
    busy_d  = busy;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          burst_d = burst_count;
          high_d  = high_clamp_c;
          low_d   = low_clamp_c;
          sent_d  = '0;
          if (burst_count == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            pulse_d = 1'b0;
          end else begin
            state_d = S_HIGH;
            phase_d = high_clamp_c;
            pulse_d = 1'b1;
            busy_d  = 1'b1;
          end
        end
      end
      S_HIGH: begin
        if (abort) begin
          state_d = S_IDLE;
          pulse_d = 1'b0;
          busy_d  = 1'b0;
        end else if (phase_q == PHASE_ONE) begin
          state_d = S_LOW;
          phase_d = low_q;
          pulse_d = 1'b0;
          sent_d  = pulses_sent + CNT_ONE;
        end else begin
          phase_d = phase_q - PHASE_ONE;
        end
      end
      S_LOW: begin
        if (abort) begin
          state_d = S_IDLE;
          pulse_d = 1'b0;
          busy_d  = 1'b0;
        end else if (phase_q == PHASE_ONE) begin
          if (pulses_sent < burst_q) begin
            state_d = S_HIGH;
            phase_d = high_q;
            pulse_d = 1'b1;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end
        end else begin
          phase_d = phase_q - PHASE_ONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        pulse_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, latched configuration and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      burst_q     <= '0;
      high_q      <= PHASE_ONE;
      low_q       <= PHASE_ONE;
      phase_q     <= PHASE_ONE;
      pulses_sent <= '0;
      pulse_out   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      burst_q     <= burst_d;
      high_q      <= high_d;
      low_q       <= low_d;
      phase_q     <= phase_d;
      pulses_sent <= sent_d;
      pulse_out   <= pulse_d;
      busy        <= busy_d;
      done        <= done_d;
    end
  end

endmodule

// File: tb/tb_pulse_burst_gen.sv
// Directed bench for pulse_burst_gen: waveform shape, zero burst, clamping,
// abort, ignored restarts and asynchronous reset.
module tb_pulse_burst_gen;

  localparam int unsigned CNT_W   = 16;
  localparam int unsigned PHASE_W = 32;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               start;
  logic               abort;
  logic [CNT_W-1:0]   burst_count;
  logic [PHASE_W-1:0] high_cycles;
  logic [PHASE_W-1:0] low_cycles;
  logic               pulse_out;
  logic               busy;
  logic               done;
  logic [CNT_W-1:0]   pulses_sent;

  int checks = 0;
  int errors = 0;

  pulse_burst_gen #(.CNT_W(CNT_W), .PHASE_W(PHASE_W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .abort       (abort),
    .burst_count (burst_count),
    .high_cycles (high_cycles),
    .low_cycles  (low_cycles),
    .pulse_out   (pulse_out),
    .busy        (busy),
    .done        (done),
    .pulses_sent (pulses_sent)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input int n, input int h, input int l);
    burst_count = CNT_W'(n);
    high_cycles = PHASE_W'(h);
    low_cycles  = PHASE_W'(l);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; abort = 1'b0;
    burst_count = '0; high_cycles = '0; low_cycles = '0;
    #12;
    checks++;
    if (pulse_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || pulses_sent !== 16'd0) begin
      errors++;
      $display("FAIL reset: pulse=%b busy=%b done=%b sent=%0d, want all 0",
               pulse_out, busy, done, pulses_sent);
    end
    @(negedge clk) reset_n = 1'b1;
    step(); step();
    checks++;
    if (pulse_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: pulse=%b busy=%b done=%b, want 0 0 0", pulse_out, busy, done);
    end
  endtask

  task automatic test_basic_burst();
    logic ep; int es;
    launch(5, 4, 6);
    for (int i = 0; i < 50; i++) begin
      ep = ((i % 10) < 4);
      es = i / 10 + (((i % 10) >= 4) ? 1 : 0);
      checks++;
      if (pulse_out !== ep || busy !== 1'b1 || done !== 1'b0 || pulses_sent !== 16'(es)) begin
        errors++;
        $display("FAIL basic_wave i=%0d: pulse=%b busy=%b done=%b sent=%0d, want %b 1 0 %0d",
                 i, pulse_out, busy, done, pulses_sent, ep, es);
      end
      step();
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || pulse_out !== 1'b0 || pulses_sent !== 16'd5) begin
      errors++;
      $display("FAIL basic_done: done=%b busy=%b pulse=%b sent=%0d, want 1 0 0 5",
               done, busy, pulse_out, pulses_sent);
    end
    step();
    checks++;
    if (done !== 1'b0 || pulses_sent !== 16'd5) begin
      errors++;
      $display("FAIL basic_strobe: done=%b sent=%0d, want 0 5", done, pulses_sent);
    end
  endtask

  task automatic test_zero_burst();
    launch(0, 4, 4);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || pulse_out !== 1'b0 || pulses_sent !== 16'd0) begin
      errors++;
      $display("FAIL zero_done: done=%b busy=%b pulse=%b sent=%0d, want 1 0 0 0",
               done, busy, pulse_out, pulses_sent);
    end
    step();
    checks++;
    if (done !== 1'b0 || pulse_out !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_after: done=%b pulse=%b busy=%b, want 0 0 0", done, pulse_out, busy);
    end
  endtask

  task automatic test_clamp();
    logic ep; int es;
    launch(3, 0, 0);
    for (int i = 0; i < 6; i++) begin
      ep = ((i % 2) == 0);
      es = i / 2 + (((i % 2) == 1) ? 1 : 0);
      checks++;
      if (pulse_out !== ep || busy !== 1'b1 || pulses_sent !== 16'(es)) begin
        errors++;
        $display("FAIL clamp_wave i=%0d: pulse=%b busy=%b sent=%0d, want %b 1 %0d",
                 i, pulse_out, busy, pulses_sent, ep, es);
      end
      step();
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || pulses_sent !== 16'd3) begin
      errors++;
      $display("FAIL clamp_done: done=%b busy=%b sent=%0d, want 1 0 3", done, busy, pulses_sent);
    end
    step();
  endtask

  task automatic test_abort();
    launch(10, 2, 2);
    for (int i = 0; i < 12; i++) step();
    checks++;
    if (pulse_out !== 1'b1 || pulses_sent !== 16'd3) begin
      errors++;
      $display("FAIL abort_pre: pulse=%b sent=%0d, want 1 3", pulse_out, pulses_sent);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if (pulse_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || pulses_sent !== 16'd3) begin
      errors++;
      $display("FAIL abort_post: pulse=%b busy=%b done=%b sent=%0d, want 0 0 0 3",
               pulse_out, busy, done, pulses_sent);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (done !== 1'b0 || pulse_out !== 1'b0) begin
        errors++;
        $display("FAIL abort_quiet i=%0d: done=%b pulse=%b, want 0 0", i, done, pulse_out);
      end
    end
    launch(2, 1, 1);
    checks++;
    if (pulses_sent !== 16'd0 || pulse_out !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_restart: sent=%0d pulse=%b busy=%b, want 0 1 1",
               pulses_sent, pulse_out, busy);
    end
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (done !== 1'b1 || pulses_sent !== 16'd2) begin
      errors++;
      $display("FAIL abort_rerun: done=%b sent=%0d, want 1 2", done, pulses_sent);
    end
    step();
  endtask

  task automatic test_ignored_start();
    logic ep; int es;
    launch(3, 2, 3);
    for (int i = 0; i < 15; i++) begin
      if (i == 3) begin
        start = 1'b1; burst_count = 16'd7; high_cycles = 32'd9; low_cycles = 32'd0;
      end
      if (i == 4) start = 1'b0;
      ep = ((i % 5) < 2);
      es = i / 5 + (((i % 5) >= 2) ? 1 : 0);
      checks++;
      if (pulse_out !== ep || busy !== 1'b1 || pulses_sent !== 16'(es)) begin
        errors++;
        $display("FAIL restart_wave i=%0d: pulse=%b busy=%b sent=%0d, want %b 1 %0d",
                 i, pulse_out, busy, pulses_sent, ep, es);
      end
      step();
    end
    checks++;
    if (done !== 1'b1 || pulses_sent !== 16'd3) begin
      errors++;
      $display("FAIL restart_done: done=%b sent=%0d, want 1 3", done, pulses_sent);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || pulse_out !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL start_in_done: busy=%b pulse=%b done=%b, want 0 0 0", busy, pulse_out, done);
    end
    burst_count = 16'd2; high_cycles = 32'd2; low_cycles = 32'd2;
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || pulse_out !== 1'b0 || done !== 1'b0 || pulses_sent !== 16'd3) begin
      errors++;
      $display("FAIL start_abort: busy=%b pulse=%b done=%b sent=%0d, want 0 0 0 3",
               busy, pulse_out, done, pulses_sent);
    end
  endtask

  task automatic test_async_reset();
    int edges; int cyc; logic prev;
    launch(4, 5, 5);
    for (int i = 0; i < 11; i++) step();
    checks++;
    if (pulse_out !== 1'b1 || pulses_sent !== 16'd1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL areset_pre: pulse=%b sent=%0d busy=%b, want 1 1 1",
               pulse_out, pulses_sent, busy);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (pulse_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || pulses_sent !== 16'd0) begin
      errors++;
      $display("FAIL areset_now: pulse=%b busy=%b done=%b sent=%0d, want 0 0 0 0",
               pulse_out, busy, done, pulses_sent);
    end
    @(negedge clk) reset_n = 1'b1;
    step();
    launch(100, 5, 5);
    edges = 0; prev = 1'b0; cyc = 0;
    while (done !== 1'b1 && cyc < 2000) begin
      if (pulse_out === 1'b1 && prev === 1'b0) edges++;
      prev = pulse_out;
      step();
      cyc++;
    end
    checks++;
    if (done !== 1'b1 || cyc != 1000) begin
      errors++;
      $display("FAIL loop_timing: done=%b cycles=%0d, want 1 1000", done, cyc);
    end
    checks++;
    if (edges != 100 || pulses_sent !== 16'h0064) begin
      errors++;
      $display("FAIL loop_count: edges=%0d sent=0x%0h, want 100 0x64", edges, pulses_sent);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_basic_burst();
    test_zero_burst();
    test_clamp();
    test_abort();
    test_ignored_start();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
